// File: rtl/gci_std_display_vram_write_buffer_if.sv
// Bus bundle for the VRAM write buffer.
// It groups the command-side write port and the arbiter port IF1.
// The master view belongs to the buffer itself. The slave view is the
// mirror image, used by whatever drives the command side and models
// the arbiter.
interface gci_std_display_vram_write_buffer_if #(
  parameter int P_MEM_ADDR_N = 23
);

  // Command stage -> buffer
  logic                    iWR_REQ;
  logic                    oWR_BUSY;
  logic [P_MEM_ADDR_N-1:0] iWR_ADDR;
  logic [31:0]             iWR_DATA;

  // Arbitration handshake
  logic                    oVRAM_ARBIT_REQ;
  logic                    iVRAM_ARBIT_ACK;
  logic                    oVRAM_ARBIT_FINISH;
  logic                    iVRAM_ARBIT_BREAK;

  // Transfer channel
  logic                    oVRAM_ENA;
  logic                    iVRAM_BUSY;
  logic                    oVRAM_RW;
  logic [P_MEM_ADDR_N-1:0] oVRAM_ADDR;
  logic [31:0]             oVRAM_DATA;

  // Status
  logic                    oIDLE;

  modport master (
    input  iWR_REQ,
    input  iWR_ADDR,
    input  iWR_DATA,
    input  iVRAM_ARBIT_ACK,
    input  iVRAM_ARBIT_BREAK,
    input  iVRAM_BUSY,
    output oWR_BUSY,
    output oVRAM_ARBIT_REQ,
    output oVRAM_ARBIT_FINISH,
    output oVRAM_ENA,
    output oVRAM_RW,
    output oVRAM_ADDR,
    output oVRAM_DATA,
    output oIDLE
  );

  modport slave (
    output iWR_REQ,
    output iWR_ADDR,
    output iWR_DATA,
    output iVRAM_ARBIT_ACK,
    output iVRAM_ARBIT_BREAK,
    output iVRAM_BUSY,
    input  oWR_BUSY,
    input  oVRAM_ARBIT_REQ,
    input  oVRAM_ARBIT_FINISH,
    input  oVRAM_ENA,
    input  oVRAM_RW,
    input  oVRAM_ADDR,
    input  oVRAM_DATA,
    input  oIDLE
  );

endinterface

// File: rtl/gci_std_display_vram_write_buffer.sv
// VRAM write buffer.
// It queues {address, data} writes coming from the display command stage.
// It wins the VRAM through the REQ/ACK/FINISH handshake, then drains the
// queue in bursts of at most P_BURST_MAX transfers per grant. It gives the
// bus back early when the arbiter raises BREAK.
module gci_std_display_vram_write_buffer #(
  parameter int P_MEM_ADDR_N   = 23,
  parameter int P_FIFO_DEPTH_N = 4,
  parameter int P_BURST_MAX    = 8
) (
  input  logic iCLOCK,
  input  logic iRESET_SYNC,
  gci_std_display_vram_write_buffer_if.master bus
);

  localparam int DEPTH   = 1 << P_FIFO_DEPTH_N;
  localparam int CNT_W   = P_FIFO_DEPTH_N + 1;
  localparam int BURST_W = $clog2(P_BURST_MAX) + 1;
  localparam int ENTRY_W = P_MEM_ADDR_N + 32;

  localparam logic [CNT_W-1:0]   FULL_COUNT = CNT_W'(DEPTH);
  localparam logic [BURST_W-1:0] BURST_LAST = BURST_W'(P_BURST_MAX - 1);

  localparam logic [1:0] L_IDLE   = 2'd0;
  localparam logic [1:0] L_REQ    = 2'd1;
  localparam logic [1:0] L_WRITE  = 2'd2;
  localparam logic [1:0] L_FINISH = 2'd3;

  // Queue storage (data only, never reset: the count decides what is valid)
  logic [ENTRY_W-1:0] mem_q [DEPTH];

  logic [P_FIFO_DEPTH_N-1:0] wr_ptr_q, wr_ptr_d;
  logic [P_FIFO_DEPTH_N-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]          count_q, count_d;
  logic [1:0]                state_q, state_d;
  logic [BURST_W-1:0]        burst_q, burst_d;

  logic full;
  logic empty;
  logic push;
  logic pop;
  logic ena;

  // Full is decoded from the registered count only. A push that arrives
  // while full is dropped, even when a pop frees a slot in the same cycle.
  assign full  = (count_q == FULL_COUNT);
  assign empty = (count_q == '0);
  assign push  = bus.iWR_REQ && !full;

  // BREAK suppresses the transfer in the cycle it is seen. A stalled
  // (BUSY) beat keeps ENA and the head in place and pops nothing.
  assign ena = (state_q == L_WRITE) && !empty && !bus.iVRAM_ARBIT_BREAK;
  assign pop = ena && !bus.iVRAM_BUSY;

  // Queue pointer and occupancy update; pointers wrap at the depth
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Arbitration and burst control
  always_comb begin
    state_d = state_q;
    burst_d = burst_q;
    case (state_q)
      L_IDLE: begin
        if (!empty) begin
          state_d = L_REQ;
        end
      end
      L_REQ: begin
        burst_d = '0;
        if (bus.iVRAM_ARBIT_ACK) begin
          state_d = L_WRITE;
        end
      end
      L_WRITE: begin
        if (pop) begin
          burst_d = burst_q + 1'b1;
        end
        // The count==0 exit looks only at the registered count. A write
        // pushed in the same cycle waits for the next grant.
        if (bus.iVRAM_ARBIT_BREAK || empty || (pop && (burst_q == BURST_LAST))) begin
          state_d = L_FINISH;
        end
      end
      L_FINISH: begin
        state_d = L_IDLE;
      end
      default: begin
        state_d = L_IDLE;
      end
    endcase
  end

  // Control registers; reset drops any queued writes and releases nothing
  always_ff @(posedge iCLOCK) begin
    if (iRESET_SYNC) begin
      state_q  <= L_IDLE;
      burst_q  <= '0;
      count_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      state_q  <= state_d;
      burst_q  <= burst_d;
      count_q  <= count_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Queue write port
  always_ff @(posedge iCLOCK) begin
    if (push) begin
      mem_q[wr_ptr_q] <= {bus.iWR_ADDR, bus.iWR_DATA};
    end
  end

  assign bus.oWR_BUSY           = full;
  assign bus.oVRAM_ARBIT_REQ    = (state_q == L_REQ);
  assign bus.oVRAM_ARBIT_FINISH = (state_q == L_FINISH);
  assign bus.oVRAM_ENA          = ena;
  assign bus.oVRAM_RW           = 1'b1;
  assign {bus.oVRAM_ADDR, bus.oVRAM_DATA} = mem_q[rd_ptr_q];
  assign bus.oIDLE              = (state_q == L_IDLE) && empty;

endmodule
